// File: rtl/outbuffer_page_writer.sv
// outbuffer_page_writer: streams bootloader/user-page bytes MSB-first into the output buffer, one bit per strobe.
// Define PAGE_WRITER_ZFILL_EN to write the 3 leading zero rows of a user page instead of skipping them.
module outbuffer_page_writer #(
  parameter int BOOT_ROWS     = 1927,
  parameter int PAGE_BASE_ROW = 7168,
  parameter int PAGE_ROWS     = 584
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        BITWIDTH4,
  input  logic        START,
  input  logic        LOADTYPE,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        nOUTBUFWRCLKEN,
  output logic [14:0] OUTBUFWRADDR,
  output logic        OUTBUFWRDATA,
  output logic        BUSY,
  output logic        DONE
);
  localparam logic [14:0] BOOT_N2 = 15'(BOOT_ROWS * 2);
  localparam logic [14:0] BOOT_N4 = 15'(BOOT_ROWS * 4);
  localparam logic [14:0] USER_N2 = 15'((PAGE_ROWS - 3) * 2);
  localparam logic [14:0] USER_N4 = 15'((PAGE_ROWS - 3) * 4);
`ifdef PAGE_WRITER_ZFILL_EN
  localparam logic [14:0] USER_A2 = 15'(PAGE_BASE_ROW * 2);
  localparam logic [14:0] USER_A4 = 15'(PAGE_BASE_ROW * 4);
`else
  localparam logic [14:0] USER_A2 = 15'((PAGE_BASE_ROW + 3) * 2);
  localparam logic [14:0] USER_A4 = 15'((PAGE_BASE_ROW + 3) * 4);
`endif

  typedef enum logic [2:0] {
    IDLE,
`ifdef PAGE_WRITER_ZFILL_EN
    ZFILL,
`endif
    FETCH,
    SHIFT,
    FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [14:0] rem_q, rem_d;
  logic [2:0]  bc_q, bc_d;
  logic [7:0]  sreg_q, sreg_d;
  logic        wr_n_q, wr_n_d;
  logic [14:0] addr_q, addr_d;
  logic        data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [14:0] start_a, start_n;
`ifdef PAGE_WRITER_ZFILL_EN
  logic [3:0]  zc_q, zc_d;
`endif

  // mode is captured into the address and remaining-bit counters at START
  assign start_n = LOADTYPE ? (BITWIDTH4 ? USER_N4 : USER_N2) : (BITWIDTH4 ? BOOT_N4 : BOOT_N2);
  assign start_a = LOADTYPE ? (BITWIDTH4 ? USER_A4 : USER_A2) : 15'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    bc_d    = bc_q;
    sreg_d  = sreg_q;
    wr_n_d  = 1'b1;
    addr_d  = addr_q;
    data_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PAGE_WRITER_ZFILL_EN
    zc_d    = zc_q;
`endif
    case (state_q)
      IDLE: if (START) begin
        busy_d  = 1'b1;
        rem_d   = start_n;
        cnt_d   = start_a;
        state_d = FETCH;
`ifdef PAGE_WRITER_ZFILL_EN
        if (LOADTYPE) begin
          state_d = ZFILL;
          wr_n_d  = 1'b0;
          addr_d  = start_a;
          cnt_d   = start_a + 15'd1;
          zc_d    = BITWIDTH4 ? 4'd11 : 4'd5;
        end
`endif
      end
`ifdef PAGE_WRITER_ZFILL_EN
      ZFILL: if (zc_q == 4'd0) state_d = FETCH;
      else begin
        wr_n_d = 1'b0;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 15'd1;
        zc_d   = zc_q - 4'd1;
      end
`endif
      FETCH: if (BYTE_VALID) begin
        state_d = SHIFT;
        wr_n_d  = 1'b0;
        addr_d  = cnt_q;
        data_d  = BYTE_IN[7];
        cnt_d   = cnt_q + 15'd1;
        rem_d   = rem_q - 15'd1;
        bc_d    = 3'd7;
        sreg_d  = {BYTE_IN[6:0], 1'b0};
      end
      // the bit shown this cycle was emitted on the previous edge
      SHIFT: if (rem_q == 15'd0) begin
        state_d = FINISH;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else if (bc_q == 3'd0) state_d = FETCH;
      else begin
        wr_n_d = 1'b0;
        addr_d = cnt_q;
        data_d = sreg_q[7];
        cnt_d  = cnt_q + 15'd1;
        rem_d  = rem_q - 15'd1;
        bc_d   = bc_q - 3'd1;
        sreg_d = {sreg_q[6:0], 1'b0};
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      bc_q    <= '0;
      sreg_q  <= '0;
      wr_n_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      bc_q    <= bc_d;
      sreg_q  <= sreg_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PAGE_WRITER_ZFILL_EN
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) zc_q <= '0;
    else zc_q <= zc_d;
  end
`endif

  assign BYTE_READY     = (state_q == FETCH);
  assign nOUTBUFWRCLKEN = wr_n_q;
  assign OUTBUFWRADDR   = addr_q;
  assign OUTBUFWRDATA   = data_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
endmodule

// File: tb/tb_outbuffer_page_writer.sv
// tb_outbuffer_page_writer: random-byte loads of every mode checked against an address/bit-stream model,
// plus stall, START-while-busy and mid-load reset scenarios.
module tb_outbuffer_page_writer;
  localparam int BOOT_ROWS = 1927, PAGE_BASE_ROW = 7168, PAGE_ROWS = 584;
`ifdef PAGE_WRITER_ZFILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic        MCLK = 1'b0, nRESET = 1'b0, BITWIDTH4 = 1'b0, START = 1'b0, LOADTYPE = 1'b0;
  logic        BYTE_VALID = 1'b0;
  logic [7:0]  BYTE_IN = 8'h00;
  logic        BYTE_READY, nOUTBUFWRCLKEN, OUTBUFWRDATA, BUSY, DONE;
  logic [14:0] OUTBUFWRADDR;

  typedef struct packed {logic [14:0] a; logic d;} wr_t;
  wr_t        wq[$];
  logic [7:0] src[512];
  int total = 0, bad = 0, nbytes = 0, done_cnt = 0;
  int nb0, wb, dc0, exp_n, exp_zf, exp_start;
  bit hold_low = 1'b0, rnd_valid = 1'b0;

  outbuffer_page_writer dut (
    .MCLK(MCLK), .nRESET(nRESET), .BITWIDTH4(BITWIDTH4), .START(START), .LOADTYPE(LOADTYPE),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .nOUTBUFWRCLKEN(nOUTBUFWRCLKEN), .OUTBUFWRADDR(OUTBUFWRADDR), .OUTBUFWRDATA(OUTBUFWRDATA),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    if (nRESET && !nOUTBUFWRCLKEN) wq.push_back({OUTBUFWRADDR, OUTBUFWRDATA});
    if (DONE) done_cnt++;
  end

  always @(posedge MCLK) if (BYTE_READY && BYTE_VALID) nbytes++;

  // byte source: always presents the next unconsumed byte of src
  initial forever begin
    @(posedge MCLK);
    #1;
    BYTE_IN = src[(nbytes - nb0) % 512];
    BYTE_VALID = !hold_low && (!rnd_valid || $urandom_range(0, 9) < 7);
  end

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic start_load(input logic bw4, input logic lt, input bit rv);
    int w;
    w = bw4 ? 4 : 2;
    exp_n = (lt ? PAGE_ROWS - 3 : BOOT_ROWS) * w;
    exp_zf = (lt && ZF) ? 3 * w : 0;
    exp_start = lt ? (PAGE_BASE_ROW + (ZF ? 0 : 3)) * w : 0;
    nb0 = nbytes;
    wb = wq.size();
    dc0 = done_cnt;
    rnd_valid = rv;
    @(posedge MCLK);
    #2;
    BITWIDTH4 = bw4;
    LOADTYPE = lt;
    START = 1'b1;
    @(posedge MCLK);
    #2;
    START = 1'b0;
    BITWIDTH4 = 1'($urandom);
    LOADTYPE = 1'($urandom);
    chk("busy_after_start", int'(BUSY), 1);
  endtask

  task automatic wait_done(input bit spam);
    int cyc = 0;
    do begin
      @(negedge MCLK);
      START = 1'b0;
      cyc++;
      if (!DONE && spam && $urandom_range(0, 15) == 0) begin
        START = 1'b1;
        BITWIDTH4 = 1'($urandom);
        LOADTYPE = 1'($urandom);
      end
    end while (!DONE && cyc < 40000);
    chk("done_seen", int'(DONE), 1);
    if (spam) START = 1'b1;
    @(negedge MCLK);
    START = 1'b0;
    chk("done_one_cycle", int'(DONE), 0);
    chk("busy_after_done", int'(BUSY), 0);
    @(negedge MCLK);
    chk("still_idle", int'(BUSY), 0);
  endtask

  task automatic check_load(input string name);
    int n_w, errs, first_bad;
    logic [7:0] b;
    logic exp_d;
    n_w = wq.size() - wb;
    errs = 0;
    first_bad = -1;
    chk({name, "_writes"}, n_w, exp_zf + exp_n);
    chk({name, "_bytes"}, nbytes - nb0, (exp_n + 7) / 8);
    chk({name, "_done_pulses"}, done_cnt - dc0, 1);
    for (int k = 0; k < n_w && k < exp_zf + exp_n; k++) begin
      if (k < exp_zf) exp_d = 1'b0;
      else begin
        b = src[(k - exp_zf) / 8];
        exp_d = b[7 - ((k - exp_zf) % 8)];
      end
      if (wq[wb + k].a !== 15'(exp_start + k) || wq[wb + k].d !== exp_d) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
    end
    if (first_bad >= 0) $display("first bad write index %0d", first_bad);
    chk({name, "_stream_errs"}, errs, 0);
    if (n_w > 0) begin
      chk({name, "_first_addr"}, int'(wq[wb].a), exp_start);
      chk({name, "_last_addr"}, int'(wq[wb + n_w - 1].a), exp_start + exp_zf + exp_n - 1);
    end
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_wren_n"}, int'(nOUTBUFWRCLKEN), 1);
    chk({name, "_addr"}, int'(OUTBUFWRADDR), 0);
    chk({name, "_data"}, int'(OUTBUFWRDATA), 0);
    chk({name, "_ready"}, int'(BYTE_READY), 0);
    chk({name, "_busy"}, int'(BUSY), 0);
    chk({name, "_done"}, int'(DONE), 0);
  endtask

  initial begin
    int cyc, drop, s, a;
    logic [7:0] pat;
    for (int i = 0; i < 512; i++) src[i] = 8'hA5;
    nb0 = 0;
    repeat (3) @(negedge MCLK);
    #1;
    check_reset_vals("reset");
    @(negedge MCLK);
    nRESET = 1'b1;

    start_load(1'b0, 1'b0, 1'b0);
    wait_done(1'b0);
    check_load("boot2_a5");
    for (int k = 0; k < 8; k++) pat[7 - k] = wq[wb + k].d;
    chk("boot2_a5_pattern", int'(pat), 8'hA5);
    chk("boot2_last_addr_abs", int'(wq[wq.size() - 1].a), 3853);

    start_load(1'b0, 1'b0, 1'b0);
    wait_done(1'b1);
    check_load("boot2_start_spam");

    for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
    start_load(1'b0, 1'b1, 1'b1);
    wait_done(1'b0);
    check_load("user2_rnd");
    start_load(1'b1, 1'b1, 1'b0);
    wait_done(1'b0);
    check_load("user4");
    chk("user4_last_addr_abs", int'(wq[wq.size() - 1].a), 31007);
    start_load(1'b1, 1'b0, 1'b1);
    wait_done(1'b1);
    check_load("boot4_rnd_spam");

    // stall: hold BYTE_VALID low while waiting in FETCH
    start_load(1'b0, 1'b0, 1'b0);
    cyc = 0;
    do begin @(negedge MCLK); cyc++; end
    while (!(nbytes - nb0 >= 10 && !BYTE_READY) && cyc < 3000);
    chk("stall_reach_shift", int'(cyc < 3000), 1);
    hold_low = 1'b1;
    cyc = 0;
    do begin @(negedge MCLK); cyc++; end
    while (!BYTE_READY && cyc < 20);
    chk("stall_reach_fetch", int'(BYTE_READY), 1);
    #1;
    s = wq.size();
    a = OUTBUFWRADDR;
    drop = 0;
    repeat (20) begin
      @(negedge MCLK);
      if (!BYTE_READY) drop++;
    end
    #1;
    chk("stall_ready_drops", drop, 0);
    chk("stall_writes", wq.size() - s, 0);
    chk("stall_addr", int'(OUTBUFWRADDR), a);
    hold_low = 1'b0;
    wait_done(1'b0);
    check_load("boot2_stall");

    // asynchronous reset in the middle of a load
    start_load(1'b0, 1'b0, 1'b0);
    cyc = 0;
    do begin @(negedge MCLK); cyc++; end
    while (!(!nOUTBUFWRCLKEN && OUTBUFWRADDR == 15'd100) && cyc < 3000);
    chk("reach_addr_100", int'(OUTBUFWRADDR), 100);
    #2;
    nRESET = 1'b0;
    #1;
    check_reset_vals("midload_reset");
    repeat (2) @(negedge MCLK);
    nRESET = 1'b1;
    start_load(1'b0, 1'b0, 1'b1);
    wait_done(1'b0);
    check_load("boot2_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/outbuffer_page_writer.md
OUTBUFFER_PAGE_WRITER -- requirements
Module: outbuffer_page_writer

Interface
REQ-001 SHALL have parameter BOOT_ROWS, default 1927, meaning the number of buffer rows written by a bootloader load (rows 0..BOOT_ROWS-1).
REQ-002 SHALL have parameter PAGE_BASE_ROW, default 7168, meaning the first buffer row of a user-page image.
REQ-003 SHALL have parameter PAGE_ROWS, default 584, meaning the total rows of a user-page image, including 3 leading zero rows.
REQ-004 MCLK  input  1  sole clock; all state updates on posedge.
REQ-005 nRESET  input  1  reset, asynchronous and active-low.
REQ-006 BITWIDTH4  input  1  0 = 2 channels per row, 1 = 4 channels per row; sampled at START.
REQ-007 START  input  1  one-cycle load request; ignored while BUSY=1.
REQ-008 LOADTYPE  input  1  0 = bootloader load, 1 = user-page load; sampled at START.
REQ-009 BYTE_IN  input  8  source byte; bit 7 is consumed first.
REQ-010 BYTE_VALID  input  1  BYTE_IN is valid.
REQ-011 BYTE_READY  output  1  writer accepts a byte this cycle.
REQ-012 nOUTBUFWRCLKEN  output  1  active-low buffer write strobe, one cycle per bit.
REQ-013 OUTBUFWRADDR  output  15  flat buffer bit address: row*2+ch (2-bit mode) or row*4+ch (4-bit mode).
REQ-014 OUTBUFWRDATA  output  1  bit to write.
REQ-015 BUSY  output  1  a load is in progress.
REQ-016 DONE  output  1  one-cycle pulse when a load completes.

Function
REQ-017 SHALL implement the FSM states IDLE, ZFILL, FETCH, SHIFT and FINISH.
REQ-018 In IDLE, START=1 SHALL latch BITWIDTH4 and LOADTYPE, set BUSY=1 on the next edge, and load the address counter.
- Start address: 0 for boot; PAGE_BASE_ROW*W for user, where W = 2 or 4.
REQ-019 IDLE SHALL transition to ZFILL for a user load when PAGE_WRITER_ZFILL_EN is defined, and to FETCH otherwise.
REQ-020 ZFILL SHALL strobe one write per cycle with OUTBUFWRDATA=0 for 3*W consecutive addresses, then go to FETCH.
REQ-021 FETCH SHALL drive BYTE_READY=1 and nOUTBUFWRCLKEN=1.
- A byte transfers on a posedge with BYTE_VALID=1 and BYTE_READY=1; the byte is captured into an 8-bit shift register and the FSM goes to SHIFT.
REQ-022 SHIFT SHALL drive BYTE_READY=0 and emit one bit per cycle, MSB first.
- Each cycle: nOUTBUFWRCLKEN=0, OUTBUFWRDATA=current bit, OUTBUFWRADDR=counter; the counter increments after each strobe.
REQ-023 Address, data and strobe SHALL be registered outputs, stable for the whole strobe cycle.
REQ-024 The total bits per load SHALL be N = rows*W, where rows = BOOT_ROWS for boot and PAGE_ROWS-3 for user (stream data only).
REQ-025 When the N-th stream bit is written, SHIFT SHALL go to FINISH immediately; unused low bits of the final byte are discarded and no further byte is requested.
REQ-026 After 8 bits with bits remaining, SHIFT SHALL return to FETCH.
REQ-027 Sustained throughput SHALL be 8 bits per 9 cycles with BYTE_VALID held at 1; a BYTE_VALID=0 stall holds FETCH indefinitely without writes.
REQ-028 FINISH SHALL pulse DONE=1 for one cycle, clear BUSY on the same edge, and return to IDLE.
REQ-029 The address counter SHALL be 15-bit; the maximum address reached (7751*4+3=31007) fits, so no wrap occurs with default parameters.
REQ-030 START asserted in any state other than IDLE SHALL be ignored; START together with DONE SHALL also be ignored.

Reset
REQ-031 nRESET=0 SHALL asynchronously force the FSM to IDLE at any time, including mid-load; the partially written buffer contents are left as is.
REQ-032 nRESET=0 SHALL force nOUTBUFWRCLKEN=1, OUTBUFWRADDR=0, OUTBUFWRDATA=0, BYTE_READY=0, BUSY=0, DONE=0, the counters to 0 and the shift register to 0.

Configuration
REQ-033 The macro PAGE_WRITER_ZFILL_EN, when defined, SHALL compile in the ZFILL state so each user load first writes 3 leading zero rows at PAGE_BASE_ROW.
REQ-034 Without PAGE_WRITER_ZFILL_EN, a user load SHALL start at (PAGE_BASE_ROW+3)*W and ZFILL logic SHALL be absent; boot loads are identical either way.

Verification
REQ-035 Boot, 2-bit mode, BYTE_VALID=1, bytes 0xA5 repeating -> 3854 strobes at addresses 0..3853 with data 1,0,1,0,0,1,0,1..., 482 bytes accepted, then DONE.
REQ-036 User, 2-bit mode, ZFILL_EN defined -> 6 zero writes at 14336..14341, then 1162 stream bits at 14342..15503, 146 bytes accepted.
REQ-037 User, 4-bit mode, ZFILL_EN undefined -> first strobe at 28684, last at 31007, 291 bytes accepted, low 4 bits of the last byte discarded.
REQ-038 BYTE_VALID held 0 for 20 cycles mid-load -> BYTE_READY stays 1, no strobes, address unchanged, then resumes correctly.
REQ-039 nRESET pulsed low during SHIFT at address 100 -> all outputs at reset values immediately; a new START restarts at address 0.
REQ-040 START pulsed while BUSY=1 -> ignored; strobe count and addresses unchanged versus REQ-035.
